// File: rtl/led_matrix_pkg.sv
// Shared types and helpers for the LED matrix scanner.
//   MAX_ROWS    : widest row strobe the helper can build
//   bank_sel_t  : selects one of the two frame banks
//   BLANK_ROW   : row strobe with every row off (active-low, all ones)
//   row_strobe  : active-low one-hot strobe for row idx of a rows-high
//                 matrix; row 0 maps to the MSB (bit rows-1)
package led_matrix_pkg;

    localparam int MAX_ROWS = 64;
    localparam int SEL_W    = $clog2(MAX_ROWS);

    typedef logic bank_sel_t;

    localparam logic [MAX_ROWS-1:0] BLANK_ROW = '1;

    function automatic logic [MAX_ROWS-1:0] row_strobe(input int unsigned idx,
                                                       input int unsigned rows);
        logic [MAX_ROWS-1:0] pat;
        pat = BLANK_ROW;
        if (idx < rows && rows <= MAX_ROWS)
            pat[SEL_W'(rows - 1 - idx)] = 1'b0;
        return pat;
    endfunction

endpackage

// File: rtl/led_matrix_scanner_if.sv
// Game-logic side of the scanner: row writes into the back buffer and the
// swap handshake.
//   wr_en/wr_row/wr_data : write one row into the back bank
//   swap_req             : ask for a bank exchange at the next frame start
//   swap_ack             : 1-cycle pulse when the banks exchange
//   swap_pending         : a swap is requested but not applied yet
// Modports: master = game logic, slave = scanner.
interface led_matrix_scanner_if #(
    parameter int ROWS = 8,
    parameter int COLS = 8
);
    localparam int RW = $clog2(ROWS);

    logic            wr_en;
    logic [RW-1:0]   wr_row;
    logic [COLS-1:0] wr_data;
    logic            swap_req;
    logic            swap_ack;
    logic            swap_pending;

    modport master (
        output wr_en, wr_row, wr_data, swap_req,
        input  swap_ack, swap_pending
    );

    modport slave (
        input  wr_en, wr_row, wr_data, swap_req,
        output swap_ack, swap_pending
    );

endinterface

// File: rtl/led_matrix_scanner_bank.sv
// frame_bank: two ROWS x COLS register banks forming a front/back pair.
//   clk, reset      : clock, synchronous active-high reset (clears both banks)
//   wr_en/row/data  : write into the current back bank; rows >= ROWS ignored
//   flip            : exchange front and back on this edge
//   rd_row, rd_data : combinational read of the front bank; while flip is
//                     high the read already comes from the bank that is
//                     about to become front
module frame_bank
    import led_matrix_pkg::*;
#(
    parameter int ROWS = 8,
    parameter int COLS = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [$clog2(ROWS)-1:0] wr_row,
    input  logic [COLS-1:0]         wr_data,
    input  logic                    flip,
    input  logic [$clog2(ROWS)-1:0] rd_row,
    output logic [COLS-1:0]         rd_data
);
    localparam int RW = $clog2(ROWS);
    localparam logic [RW:0] ROW_LIM = ROWS;

    logic [COLS-1:0] mem [2][ROWS];
    bank_sel_t       front;
    logic            wr_ok;

    assign wr_ok   = wr_en && ({1'b0, wr_row} < ROW_LIM);
    assign rd_data = mem[flip ? ~front : front][rd_row];

    always_ff @(posedge clk) begin
        if (reset) begin
            front <= 1'b0;
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < ROWS; r++)
                    mem[b][r] <= '0;
        end else begin
            if (flip)
                front <= ~front;
            // Uses the pre-flip back bank even in the flip cycle.
            if (wr_ok)
                mem[~front][wr_row] <= wr_data;
        end
    end

endmodule

// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: double-buffered multiplexed scan driver for a
// ROWS x COLS LED dot matrix. Each row stays lit for ROW_CYCLES clocks; a
// requested buffer swap is applied only when the scan wraps to row 0.
// Optional feature macro LED_SCAN_PWM_EN adds a brightness port and a
// free-running PWM counter that gates dot_col.
//   clk, reset   : clock, synchronous active-high reset
//   bus          : write/swap interface (slave modport)
//   brightness   : duty level, only with LED_SCAN_PWM_EN
//   dot_row      : active-low one-hot row strobe, row 0 = MSB
//   dot_col      : active-high column drive for the lit row
//   row_idx      : index of the row currently driven
//   frame_start  : 1-cycle pulse when row 0 becomes selected
module led_matrix_scanner
    import led_matrix_pkg::*;
#(
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int ROW_CYCLES = 50002
`ifdef LED_SCAN_PWM_EN
    ,
    parameter int BRIGHT_W   = 4
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    led_matrix_scanner_if.slave     bus,
`ifdef LED_SCAN_PWM_EN
    input  logic [BRIGHT_W-1:0]     brightness,
`endif
    output logic [ROWS-1:0]         dot_row,
    output logic [COLS-1:0]         dot_col,
    output logic [$clog2(ROWS)-1:0] row_idx,
    output logic                    frame_start
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(ROW_CYCLES);

    logic [CW-1:0]   div_cnt;
    logic [RW-1:0]   row_q;
    logic [RW-1:0]   next_row;
    logic [ROWS-1:0] next_strobe;
    logic [COLS-1:0] rd_data;
    logic [COLS-1:0] col_q;
    logic            tick;
    logic            wrap;
    logic            do_swap;
    logic            pending_q;
    logic            ack_q;
    logic            fs_q;

    assign tick     = (div_cnt == CW'(ROW_CYCLES - 1));
    assign wrap     = tick && (row_q == RW'(ROWS - 1));
    // A request arriving in the wrap cycle itself is honoured immediately.
    assign do_swap  = wrap && (pending_q || bus.swap_req);
    assign next_row = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;

    always_comb begin
        next_strobe = ROWS'(row_strobe(32'(next_row), ROWS));
    end

    frame_bank #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_bank (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (bus.wr_en),
        .wr_row  (bus.wr_row),
        .wr_data (bus.wr_data),
        .flip    (do_swap),
        .rd_row  (next_row),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt   <= '0;
            row_q     <= '0;
            dot_row   <= ROWS'(BLANK_ROW);
            col_q     <= '0;
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
            fs_q      <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            ack_q   <= do_swap;
            fs_q    <= wrap;
            if (do_swap)
                pending_q <= 1'b0;
            else if (bus.swap_req)
                pending_q <= 1'b1;
            // Strobe and column data move together so no ghosting appears.
            if (tick) begin
                row_q   <= next_row;
                dot_row <= next_strobe;
                col_q   <= rd_data;
            end
        end
    end

`ifdef LED_SCAN_PWM_EN
    logic [BRIGHT_W-1:0] pwm_cnt;

    always_ff @(posedge clk) begin
        if (reset)
            pwm_cnt <= '0;
        else
            pwm_cnt <= pwm_cnt + 1'b1;
    end

    assign dot_col = col_q & {COLS{pwm_cnt < brightness}};
`else
    assign dot_col = col_q;
`endif

    assign row_idx          = row_q;
    assign frame_start      = fs_q;
    assign bus.swap_ack     = ack_q;
    assign bus.swap_pending = pending_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
module tb_led_matrix_scanner;
    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int RC   = 4;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] dot_row;
    logic [7:0] dot_col;
    logic [2:0] row_idx;
    logic       frame_start;
`ifdef LED_SCAN_PWM_EN
    logic [3:0] brightness = 4'hF;
`endif

    led_matrix_scanner_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

    led_matrix_scanner #(
        .ROWS       (ROWS),
        .COLS       (COLS),
        .ROW_CYCLES (RC)
`ifdef LED_SCAN_PWM_EN
        ,
        .BRIGHT_W   (4)
`endif
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
`ifdef LED_SCAN_PWM_EN
        .brightness  (brightness),
`endif
        .dot_row     (dot_row),
        .dot_col     (dot_col),
        .row_idx     (row_idx),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: edge count since reset decides the scan position.
    logic [7:0] mbank [2][8];
    int         mf, midx, medges;
    bit         mpend, mfs, mack;
    logic [7:0] mrow, mcol;

    localparam logic [21:0] RESET_VEC = {8'hFF, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};

    wire [21:0] dut_vec = {dot_row, dot_col, row_idx, frame_start,
                           bus.swap_ack, bus.swap_pending};

    function automatic logic [21:0] exp_vec();
        logic [7:0] g;
        g = mcol;
`ifdef LED_SCAN_PWM_EN
        if ((medges % 16) >= int'(brightness)) g = 8'h00;
`endif
        return {mrow, g, 3'(midx), mfs, mack, mpend};
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < 8; r++) mbank[b][r] = 8'h00;
        mf = 0; midx = 0; medges = 0;
        mpend = 0; mfs = 0; mack = 0;
        mrow = 8'hFF; mcol = 8'h00;
    endtask

    // Advance one clock; model follows the behavioural rules, then #1 settle.
    task automatic step();
        bit tick, wrap, sw;
        int nr;
        logic [7:0] ncol;
        tick = (medges % RC) == RC - 1;
        wrap = tick && (midx == ROWS - 1);
        sw   = wrap && (mpend || bus.swap_req);
        nr   = (midx + 1) % ROWS;
        ncol = mbank[sw ? 1 - mf : mf][nr];
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            if (bus.wr_en && int'(bus.wr_row) < ROWS) mbank[1 - mf][bus.wr_row] = bus.wr_data;
            if (tick) begin
                midx = nr;
                mrow = ~(8'h80 >> nr);
                mcol = ncol;
            end
            mfs  = wrap;
            mack = sw;
            if (sw) begin mf = 1 - mf; mpend = 0; end
            else if (bus.swap_req) mpend = 1;
            medges++;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (dut_vec !== RESET_VEC)
                $display("FAIL reset_hold: got %h want %h", dut_vec, RESET_VEC);
            else n_pass++;
        end
        reset = 1'b0;
    endtask

    task automatic test_scan();
        for (int e = 1; e <= 40; e++) begin
            step();
            n_checks++;
            if (dut_vec !== exp_vec())
                $display("FAIL scan e=%0d: got %h want %h", e, dut_vec, exp_vec());
            else n_pass++;
            if (e == 3 || e == 4) begin
                n_checks++;
                if (dot_row !== ((e == 3) ? 8'hFF : 8'hBF))
                    $display("FAIL first_tick e=%0d: got %h want %h", e, dot_row,
                             (e == 3) ? 8'hFF : 8'hBF);
                else n_pass++;
            end
        end
    endtask

    task automatic test_swap_mid();
        bit seen;
        for (int n = 0; n < 8; n++) begin
            bus.wr_en = 1'b1; bus.wr_row = 3'(n); bus.wr_data = 8'h01 << n;
            step();
        end
        bus.wr_en = 1'b0;
        if ((medges % RC) == RC - 1 && midx == ROWS - 1) step();
        bus.swap_req = 1'b1;
        step();
        bus.swap_req = 1'b0;
        n_checks++;
        if (bus.swap_pending !== 1'b1)
            $display("FAIL swap_pending_set: got %b want 1", bus.swap_pending);
        else n_pass++;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            n_checks++;
            if (dut_vec !== exp_vec())
                $display("FAIL swap_mid: got %h want %h", dut_vec, exp_vec());
            else n_pass++;
            if (frame_start === 1'b1 && bus.swap_ack === 1'b1) seen = 1;
        end
        n_checks++;
        if (seen !== 1'b1) $display("FAIL swap_ack_seen: got 0 want 1");
        else n_pass++;
        for (int i = 0; i < 32; i++) begin
            step();
            n_checks++;
            if (dut_vec !== exp_vec())
                $display("FAIL swap_mid_show: got %h want %h", dut_vec, exp_vec());
            else n_pass++;
`ifndef LED_SCAN_PWM_EN
            n_checks++;
            if (dot_col !== (8'h01 << row_idx))
                $display("FAIL swap_mid_col row=%0d: got %h want %h", row_idx, dot_col,
                         8'h01 << row_idx);
            else n_pass++;
`endif
        end
    endtask

    task automatic test_no_swap();
        bus.wr_en = 1'b1; bus.wr_row = 3'd3; bus.wr_data = 8'hAA;
        step();
        bus.wr_en = 1'b0;
        for (int i = 0; i < 64; i++) begin
            step();
            n_checks++;
            if (dut_vec !== exp_vec())
                $display("FAIL no_swap: got %h want %h", dut_vec, exp_vec());
            else n_pass++;
`ifndef LED_SCAN_PWM_EN
            if (row_idx == 3'd3 && dot_row == 8'hEF) begin
                n_checks++;
                if (dot_col !== 8'h08)
                    $display("FAIL no_swap_row3: got %h want 08", dot_col);
                else n_pass++;
            end
`endif
        end
    endtask

    task automatic test_swap_on_wrap();
        bit found;
        for (int n = 0; n < 8; n++) begin
            bus.wr_en = 1'b1; bus.wr_row = 3'(n); bus.wr_data = 8'($urandom);
            step();
        end
        bus.wr_en = 1'b0;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if ((medges % RC) == RC - 1 && midx == ROWS - 1) found = 1;
            else step();
        end
        n_checks++;
        if (found !== 1'b1) $display("FAIL wrap_reached: got 0 want 1");
        else n_pass++;
        bus.swap_req = 1'b1;
        step();
        bus.swap_req = 1'b0;
        n_checks++;
        if ({bus.swap_ack, frame_start, bus.swap_pending} !== 3'b110)
            $display("FAIL swap_on_wrap: got ack/fs/pend %b want 110",
                     {bus.swap_ack, frame_start, bus.swap_pending});
        else n_pass++;
        for (int i = 0; i < 32; i++) begin
            step();
            n_checks++;
            if (dut_vec !== exp_vec())
                $display("FAIL swap_on_wrap_run: got %h want %h", dut_vec, exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            bus.wr_en    = 1'($urandom);
            bus.wr_row   = 3'($urandom);
            bus.wr_data  = 8'($urandom);
            bus.swap_req = ($urandom % 8) == 0;
            step();
            n_checks++;
            if (dut_vec !== exp_vec())
                $display("FAIL random i=%0d: got %h want %h", i, dut_vec, exp_vec());
            else n_pass++;
        end
        bus.wr_en = 1'b0; bus.swap_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit found;
        for (int n = 0; n < 8; n++) begin
            bus.wr_en = 1'b1; bus.wr_row = 3'(n); bus.wr_data = 8'($urandom) | 8'h01;
            step();
        end
        bus.wr_en = 1'b0;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (midx == 5) found = 1;
            else step();
        end
        bus.swap_req = 1'b1;
        step();
        bus.swap_req = 1'b0;
        n_checks++;
        if (bus.swap_pending !== 1'b1 || row_idx !== 3'd5)
            $display("FAIL pre_reset: got pend=%b row=%0d want pend=1 row=5",
                     bus.swap_pending, row_idx);
        else n_pass++;
        reset = 1'b1;
        step();
        n_checks++;
        if (dut_vec !== RESET_VEC)
            $display("FAIL reset_mid: got %h want %h", dut_vec, RESET_VEC);
        else n_pass++;
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            bus.swap_req = (i == 10);
            step();
            n_checks++;
            if (dot_col !== 8'h00)
                $display("FAIL banks_cleared: got %h want 00", dot_col);
            else n_pass++;
        end
        bus.swap_req = 1'b0;
    endtask

`ifdef LED_SCAN_PWM_EN
    task automatic test_pwm();
        bit seen;
        int on;
        for (int n = 0; n < 8; n++) begin
            bus.wr_en = 1'b1; bus.wr_row = 3'(n); bus.wr_data = 8'hFF;
            step();
        end
        bus.wr_en = 1'b0;
        bus.swap_req = 1'b1;
        step();
        bus.swap_req = 1'b0;
        seen = mack;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            seen = mack;
        end
        n_checks++;
        if (bus.swap_ack !== 1'b1) $display("FAIL pwm_swap: got ack %b want 1", bus.swap_ack);
        else n_pass++;
        brightness = 4'd4;
        on = 0;
        for (int i = 0; i < 32; i++) begin
            step();
            if (dot_col == 8'hFF) on++;
        end
        n_checks++;
        if (on != 8) $display("FAIL pwm_duty4: got %0d on-cycles want 8", on);
        else n_pass++;
        brightness = 4'd0;
        on = 0;
        for (int i = 0; i < 32; i++) begin
            step();
            if (dot_col != 8'h00) on++;
        end
        n_checks++;
        if (on != 0) $display("FAIL pwm_dark: got %0d on-cycles want 0", on);
        else n_pass++;
        brightness = 4'hF;
    endtask
`endif

    initial begin
        bus.wr_en = 1'b0; bus.wr_row = '0; bus.wr_data = '0; bus.swap_req = 1'b0;
        model_reset();
        #1;
        test_reset();
        test_scan();
        test_swap_mid();
        test_no_swap();
        test_swap_on_wrap();
        test_random();
        test_reset_mid();
`ifdef LED_SCAN_PWM_EN
        test_pwm();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
